// File: rtl/exec_unit_mc.sv
// Multi-cycle execute stage: accepts one decoded instruction, reads operands from the
// internal register file, executes (iterative shift-add for MUL), writes back and pulses a result.
module exec_unit_mc #(
  parameter int XLEN = 32,
  parameter int PC_W = 8,
  parameter int NREG = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [PC_W-1:0] pc_i,
  input  logic [1:0]      type_i,
  input  logic [5:0]      opc_i,
  input  logic [RA_W-1:0] rs_i,
  input  logic [RA_W-1:0] rt_i,
  input  logic [RA_W-1:0] rd_i,
  input  logic [5:0]      funct_i,
  input  logic [4:0]      shamt_i,
  input  logic [15:0]     imm_i,
  input  logic [25:0]     iindex_i,
  output logic            out_valid_o,
  output logic [PC_W-1:0] nextpc_o,
  output logic [XLEN-1:0] regvalue_o,
  output logic            illegal_o,
  output logic            busy_o,
  input  logic [RA_W-1:0] dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [1:0] T_I = 2'b00;
  localparam logic [1:0] T_R = 2'b01;
  localparam logic [1:0] T_J = 2'b10;

  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_MUL  = 6'b011000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_e;

  state_e             state_q;
  logic [XLEN-1:0]    regs_q [NREG];

  logic [PC_W-1:0]    pc_q;
  logic [1:0]         type_q;
  logic [5:0]         opc_q;
  logic [5:0]         funct_q;
  logic [RA_W-1:0]    rt_idx_q;
  logic [RA_W-1:0]    rd_idx_q;
  logic [4:0]         shamt_q;
  logic [15:0]        imm_q;
  logic [PC_W-1:0]    jtgt_q;
  logic [XLEN-1:0]    a_q;
  logic [XLEN-1:0]    b_q;
  logic [XLEN-1:0]    acc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               out_valid_q;
  logic [PC_W-1:0]    nextpc_q;
  logic [XLEN-1:0]    regvalue_q;
  logic               illegal_q;

  logic [XLEN-1:0]    rs_val;
  logic [XLEN-1:0]    rt_val;
  logic               is_mul;

  logic [PC_W-1:0]    pc_inc;
  logic [XLEN-1:0]    simm;
  logic [XLEN-1:0]    zimm;
  logic               wr_en;
  logic [RA_W-1:0]    wr_idx;
  logic [XLEN-1:0]    wr_val;
  logic [PC_W-1:0]    npc;
  logic               ill;

  logic               unused_iindex;

  // r0 and indices beyond the implemented file behave as constant zero / write sink.
  function automatic logic idx_ok(input logic [RA_W-1:0] idx);
    return (idx != '0) && (int'(idx) < NREG);
  endfunction

  assign rs_val     = idx_ok(rs_i) ? regs_q[rs_i] : '0;
  assign rt_val     = idx_ok(rt_i) ? regs_q[rt_i] : '0;
  assign dbg_data_o = idx_ok(dbg_addr_i) ? regs_q[dbg_addr_i] : '0;

  assign is_mul = (type_i == T_R) && (opc_i == OP_RTYPE) && (funct_i == FN_MUL);

  assign unused_iindex = ^iindex_i;

  always_comb begin
    pc_inc = pc_q + PC_W'(1);
    simm   = {{(XLEN-16){imm_q[15]}}, imm_q};
    zimm   = {{(XLEN-16){1'b0}}, imm_q};
    wr_en  = 1'b0;
    wr_idx = rd_idx_q;
    wr_val = '0;
    npc    = pc_inc;
    ill    = 1'b0;
    case (type_q)
      T_I: begin
        wr_idx = rt_idx_q;
        case (opc_q)
          OP_ADDIU: begin wr_en = 1'b1; wr_val = a_q + simm; end
          OP_ANDI:  begin wr_en = 1'b1; wr_val = a_q & zimm; end
          OP_ORI:   begin wr_en = 1'b1; wr_val = a_q | zimm; end
          OP_BEQ:   if (a_q == b_q) npc = pc_inc + simm[PC_W-1:0];
          default:  ill = 1'b1;
        endcase
      end
      T_R: begin
        if (opc_q != OP_RTYPE) begin
          ill = 1'b1;
        end else begin
          wr_en = 1'b1;
          case (funct_q)
            FN_ADDU: wr_val = a_q + b_q;
            FN_SUBU: wr_val = a_q - b_q;
            FN_AND:  wr_val = a_q & b_q;
            FN_OR:   wr_val = a_q | b_q;
            FN_SLL:  wr_val = b_q << shamt_q;
            FN_SRL:  wr_val = b_q >> shamt_q;
            FN_MUL:  wr_val = acc_q;
            default: begin wr_en = 1'b0; ill = 1'b1; end
          endcase
        end
      end
      T_J:     npc = jtgt_q;
      default: ill = 1'b1;
    endcase
    if (!idx_ok(wr_idx)) wr_en = 1'b0;
  end

  // rst is expected to arrive with its release already synchronised to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      pc_q        <= '0;
      type_q      <= '0;
      opc_q       <= '0;
      funct_q     <= '0;
      rt_idx_q    <= '0;
      rd_idx_q    <= '0;
      shamt_q     <= '0;
      imm_q       <= '0;
      jtgt_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      nextpc_q    <= '0;
      regvalue_q  <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            pc_q     <= pc_i;
            type_q   <= type_i;
            opc_q    <= opc_i;
            funct_q  <= funct_i;
            rt_idx_q <= rt_i;
            rd_idx_q <= rd_i;
            shamt_q  <= shamt_i;
            imm_q    <= imm_i;
            jtgt_q   <= iindex_i[PC_W-1:0];
            a_q      <= rs_val;
            b_q      <= rt_val;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= is_mul ? S_MUL : S_EXEC;
          end
        end
        // One multiplier bit per cycle; a_q is the shifted multiplicand, b_q the remaining multiplier.
        S_MUL: begin
          if (b_q[0]) acc_q <= acc_q + a_q;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (wr_en) regs_q[wr_idx] <= wr_val;
          nextpc_q    <= npc;
          regvalue_q  <= wr_en ? wr_val : '0;
          illegal_q   <= ill;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign busy_o      = (state_q == S_EXEC) || (state_q == S_MUL);
  assign out_valid_o = out_valid_q;
  assign nextpc_o    = nextpc_q;
  assign regvalue_o  = regvalue_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Bench for exec_unit_mc: directed scenarios plus random instructions against an
// architectural register-file model.
module tb_exec_unit_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  pc = '0;
  logic [1:0]  ty = '0;
  logic [5:0]  opc = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [5:0]  funct = '0;
  logic [4:0]  shamt = '0;
  logic [15:0] imm = '0;
  logic [25:0] iindex = '0;
  logic        out_valid;
  logic [7:0]  nextpc;
  logic [31:0] regvalue;
  logic        illegal;
  logic        busy;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m [32];

  exec_unit_mc dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pc_i(pc), .type_i(ty), .opc_i(opc),
    .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .funct_i(funct), .shamt_i(shamt), .imm_i(imm), .iindex_i(iindex),
    .out_valid_o(out_valid), .nextpc_o(nextpc), .regvalue_o(regvalue),
    .illegal_o(illegal), .busy_o(busy),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural behaviour of one instruction; updates the model register file.
  task automatic ref_exec(input logic [1:0] t, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] s, input logic [4:0] u, input logic [4:0] d,
                          input logic [4:0] sh, input logic [15:0] im, input logic [25:0] ii,
                          input logic [7:0] p,
                          output logic [7:0] enp, output logic [31:0] erv, output logic eill,
                          output int elat, output int widx);
    logic [31:0] a, b, v;
    bit wr;
    a = m[s]; b = m[u];
    enp = p + 8'd1; eill = 1'b0; elat = 1; wr = 0; widx = -1; v = '0;
    if (t == 2'd0) begin
      case (op)
        6'd9:  begin wr = 1; v = a + 32'(signed'(im)); end
        6'd12: begin wr = 1; v = a & {16'h0, im}; end
        6'd13: begin wr = 1; v = a | {16'h0, im}; end
        6'd4:  if (a == b) enp = p + 8'd1 + im[7:0];
        default: eill = 1'b1;
      endcase
      if (wr) widx = int'(u);
    end else if (t == 2'd1) begin
      if (op != 0) eill = 1'b1;
      else begin
        wr = 1;
        case (fn)
          6'd33: v = a + b;
          6'd35: v = a - b;
          6'd36: v = a & b;
          6'd37: v = a | b;
          6'd0:  v = b << sh;
          6'd2:  v = b >> sh;
          6'd24: begin v = 32'(64'(a) * 64'(b)); elat = 33; end
          default: begin wr = 0; eill = 1'b1; end
        endcase
        if (wr) widx = int'(d);
      end
    end else if (t == 2'd2) begin
      enp = ii[7:0];
    end else begin
      eill = 1'b1;
    end
    erv = '0;
    if (widx > 0) begin
      m[widx] = v;
      erv = v;
    end
  endtask

  task automatic issue(input string nm, input logic [1:0] t, input logic [5:0] op,
                       input logic [5:0] fn, input logic [4:0] s, input logic [4:0] u,
                       input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im,
                       input logic [25:0] ii, input logic [7:0] p);
    logic [7:0] enp; logic [31:0] erv; logic eill; int elat, widx;
    int g, lat, rdy_hi, busy_lo;
    bit got;
    ref_exec(t, op, fn, s, u, d, sh, im, ii, p, enp, erv, eill, elat, widx);
    g = 0;
    while (!in_ready && g < 60) begin @(negedge clk); g++; end
    chk({nm, ".ready"}, in_ready, 1);
    ty = t; opc = op; funct = fn; rs = s; rt = u; rd = d; shamt = sh; imm = im; iindex = ii; pc = p;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk({nm, ".pulse_end"}, out_valid, 0);
    lat = 0; got = 0; rdy_hi = 0; busy_lo = 0;
    while (!got && lat < 100) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (out_valid) got = 1;
      else begin
        if (in_ready) rdy_hi++;
        if (!busy) busy_lo++;
      end
    end
    chk({nm, ".latency"}, lat, elat);
    chk({nm, ".ready_low"}, rdy_hi, 0);
    chk({nm, ".busy_high"}, busy_lo, 0);
    chk({nm, ".nextpc"}, nextpc, enp);
    chk({nm, ".regvalue"}, regvalue, erv);
    chk({nm, ".illegal"}, illegal, eill);
    if (widx >= 0) begin
      dbg_addr = 5'(widx);
      #1 chk({nm, ".dbg"}, dbg_data, m[widx]);
    end
  endtask

  task automatic check_cleared(input string nm);
    chk({nm, ".out_valid"}, out_valid, 0);
    chk({nm, ".nextpc"}, nextpc, 0);
    chk({nm, ".regvalue"}, regvalue, 0);
    chk({nm, ".illegal"}, illegal, 0);
    chk({nm, ".in_ready"}, in_ready, 1);
    chk({nm, ".busy"}, busy, 0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 chk({nm, ".reg"}, dbg_data, 0);
    end
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 32; i++) m[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_cleared("reset");

    // Directed scenarios
    issue("addiu5",  2'd0, 6'd9,  6'd0, 5'd0, 5'd1, 5'd0, 5'd0, 16'd5,    26'd0, 8'h10);
    issue("addiu_m1",2'd0, 6'd9,  6'd0, 5'd0, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0, 8'h11);
    issue("ori",     2'd0, 6'd13, 6'd0, 5'd0, 5'd3, 5'd0, 5'd0, 16'hFFFF, 26'd0, 8'h12);
    issue("andi",    2'd0, 6'd12, 6'd0, 5'd2, 5'd5, 5'd0, 5'd0, 16'h8F0F, 26'd0, 8'h13);
    issue("set_r1",  2'd0, 6'd9,  6'd0, 5'd0, 5'd1, 5'd0, 5'd0, 16'd7,    26'd0, 8'h14);
    issue("set_r2",  2'd0, 6'd9,  6'd0, 5'd0, 5'd2, 5'd0, 5'd0, 16'd6,    26'd0, 8'h15);
    issue("mul42",   2'd1, 6'd0,  6'd24, 5'd1, 5'd2, 5'd4, 5'd0, 16'd0,   26'd0, 8'h16);
    issue("beq_wrap",2'd0, 6'd4,  6'd0, 5'd1, 5'd1, 5'd0, 5'd0, 16'd3,    26'd0, 8'hFE);
    issue("beq_ne",  2'd0, 6'd4,  6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'd3,    26'd0, 8'hFE);
    issue("beq_back",2'd0, 6'd4,  6'd0, 5'd2, 5'd2, 5'd0, 5'd0, 16'hFFFC, 26'd0, 8'h01);
    issue("addu_r0", 2'd1, 6'd0,  6'd33, 5'd1, 5'd2, 5'd0, 5'd0, 16'd0,   26'd0, 8'h20);
    dbg_addr = 5'd0;
    #1 chk("r0_zero", dbg_data, 0);
    issue("type3",   2'd3, 6'd9,  6'd33, 5'd1, 5'd2, 5'd6, 5'd0, 16'd1,   26'd0, 8'h30);
    issue("jump",    2'd2, 6'd2,  6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FFFF5A, 8'h40);
    issue("sll",     2'd1, 6'd0,  6'd0, 5'd0, 5'd2, 5'd7, 5'd31, 16'd0,   26'd0, 8'h41);
    issue("srl",     2'd1, 6'd0,  6'd2, 5'd0, 5'd7, 5'd8, 5'd4, 16'd0,    26'd0, 8'h42);
    issue("subu",    2'd1, 6'd0,  6'd35, 5'd2, 5'd1, 5'd9, 5'd0, 16'd0,   26'd0, 8'h43);

    // Randomised instruction mix
    for (int k = 0; k < 250; k++) begin
      logic [1:0] t; logic [5:0] op, fn; logic [4:0] s, u, d, sh;
      logic [15:0] im; logic [25:0] ii; logic [7:0] p;
      int sel;
      t = 2'($urandom); op = 6'($urandom); fn = 6'($urandom);
      s = 5'($urandom); u = 5'($urandom); d = 5'($urandom); sh = 5'($urandom);
      im = 16'($urandom); ii = 26'($urandom); p = 8'($urandom);
      sel = $urandom_range(0, 12);
      case (sel)
        0: begin t = 0; op = 6'd9;  end
        1: begin t = 0; op = 6'd12; end
        2: begin t = 0; op = 6'd13; end
        3: begin t = 0; op = 6'd4; if ($urandom_range(0, 1) == 1) u = s; end
        4: begin t = 1; op = 0; fn = 6'd33; end
        5: begin t = 1; op = 0; fn = 6'd35; end
        6: begin t = 1; op = 0; fn = 6'd36; end
        7: begin t = 1; op = 0; fn = 6'd37; end
        8: begin t = 1; op = 0; fn = 6'd0;  end
        9: begin t = 1; op = 0; fn = 6'd2;  end
        10: begin t = 1; op = 0; fn = 6'd24; end
        11: t = 2;
        default: ;
      endcase
      issue("rand", t, op, fn, s, u, d, sh, im, ii, p);
    end

    // Reset in the middle of a multiply aborts it
    @(negedge clk);
    ty = 2'd1; opc = 6'd0; funct = 6'd24; rs = 5'd1; rt = 5'd2; rd = 5'd10;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 32; i++) m[i] = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort.no_pulse", seen, 0);
    check_cleared("abort");
    issue("post_abort", 2'd0, 6'd9, 6'd0, 5'd0, 5'd11, 5'd0, 5'd0, 16'h1234, 26'd0, 8'h50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
